sdbank_multi_switch: RTL and testbench
======================================

SDBANK_MULTI_SWITCH -- requirements
Module: sdbank_multi_switch

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3; number of SDRAM frame banks, legal 3..4.
REQ-002 SHALL have parameter BANK_W, default 2; bank index width, NUM_BANKS <= 2**BANK_W.
REQ-003 SHALL have parameter CNT_W, default 16; status counter width.
REQ-004 SHALL have ports: clk input 1 (sole clock); rst_n input 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports: bank_valid input 1, frame sync (high during frame); frame_write_done input 1, writer finished current frame; frame_read_done input 1, reader finished current frame.
REQ-006 SHALL have ports: wr_bank output BANK_W, bank being written; rd_bank output BANK_W, bank being read; wr_load output 1, writer address reload pulse; rd_load output 1, reader address reload pulse.
REQ-007 SHALL have ports: frame_drop output 1, pulse when an unread completed frame is discarded; frame_repeat output 1, pulse when the reader restarts on the same bank.
REQ-008 SHALL have ports under SDBANK_STATS_EN only: drop_cnt output CNT_W; repeat_cnt output CNT_W.

Function
REQ-009 SHALL register bank_valid through two flops; switch_flag = 1 for one cycle on the falling edge (r1 & ~r0).
REQ-010 SHALL track internally: latest (BANK_W) and latest_vld, naming the newest completed, unread bank.
REQ-011 SHALL keep wr_bank, rd_bank, and latest (when latest_vld) pairwise distinct in every cycle.
REQ-012 Writer FSM SHALL use W_IDLE->W_ARM (1 cycle)->W_WAIT_SYNC; on switch_flag, wr_load=1 for exactly one cycle (W_LOAD), then W_WAIT_DONE.
REQ-013 In W_WAIT_DONE, on frame_write_done: latest<=wr_bank, latest_vld<=1, wr_bank<=lowest index not equal to rd_bank and not equal to the completed bank, then W_IDLE.
REQ-014 If latest_vld was already 1 at write completion and the reader does not complete in the same cycle, frame_drop SHALL pulse one cycle (old latest overwritten/freed).
REQ-015 Reader FSM SHALL use R_IDLE->R_LOAD (rd_load=1 one cycle)->R_GAP (rd_load=0)->R_WAIT_SYNC; on switch_flag->R_WAIT_DONE.
REQ-016 In R_WAIT_DONE, on frame_read_done with latest_vld=1: rd_bank<=latest, latest_vld<=0, then R_IDLE.
REQ-017 In R_WAIT_DONE, on frame_read_done with latest_vld=0: rd_bank unchanged, frame_repeat pulses one cycle, then R_IDLE.
REQ-018 On simultaneous write completion and read completion: reader SHALL take the just-completed bank, latest_vld<=0, no frame_drop; writer's next bank per REQ-013 using the pre-update rd_bank.
REQ-019 frame_write_done/frame_read_done outside their WAIT_DONE states SHALL be ignored.
REQ-020 A switch_flag arriving in any other state SHALL be ignored (no queuing).
REQ-021 All outputs SHALL be registered; bank updates visible the cycle after the done input.

Reset
REQ-022 On rst_n low: wr_bank=0, rd_bank=NUM_BANKS-1, latest=0, latest_vld=0, all pulses 0, FSMs in W_IDLE/R_IDLE, sync flops 0, counters 0.
REQ-023 Reset mid-frame SHALL abort both FSMs immediately; after release, the first rd_load appears within 2 cycles.

Configuration
REQ-024 With SDBANK_STATS_EN defined: drop_cnt/repeat_cnt increment on frame_drop/frame_repeat, saturating at 2**CNT_W-1; without it, ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-025 Package sdbank_pkg SHALL hold the writer/reader state enums and the MAX_BANKS=4 constant.
REQ-026 Sub-module sdbank_edge_det SHALL implement REQ-009 (2-flop register + negedge pulse).

Verification
REQ-027 Reset release, NUM_BANKS=3 -> wr_bank=0, rd_bank=2, rd_load pulse once; wr_load=0 until the first bank_valid fall.
REQ-028 bank_valid fall then frame_write_done -> wr_load 1 cycle after edge; latest=0, latest_vld=1, wr_bank=1.
REQ-029 Two write completions, no read completion -> second completion: frame_drop=1, latest=1, wr_bank=0.
REQ-030 frame_read_done with latest_vld=0 -> frame_repeat=1, rd_bank stays 2; with latest_vld=1 -> rd_bank=latest.
REQ-031 Write and read done in the same cycle (wr=0, rd=2, latest invalid) -> rd_bank=0, wr_bank=1, no drop.
REQ-032 SDBANK_STATS_EN, CNT_W=2, 5 forced repeats -> repeat_cnt saturates at 3; 1000 random cycles -> banks always distinct.

Source files
------------

// File: rtl/sdbank_pkg.sv
// Shared types for the SDRAM frame-bank switch: writer/reader FSM states
// and the largest supported bank count.
package sdbank_pkg;

    localparam int MAX_BANKS = 4;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ARM,
        W_WAIT_SYNC,
        W_LOAD,
        W_WAIT_DONE
    } wr_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_LOAD,
        R_GAP,
        R_WAIT_SYNC,
        R_WAIT_DONE
    } rd_state_t;

endpackage

// File: rtl/sdbank_edge_det.sv
// Two-flop register of the frame sync; pulses switch_flag for one cycle
// when the registered sync falls.
module sdbank_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic bank_valid,
    output logic switch_flag
);

    logic r0;
    logic r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= 1'b0;
            r1 <= 1'b0;
        end else begin
            r0 <= bank_valid;
            r1 <= r0;
        end
    end

    assign switch_flag = r1 & ~r0;

endmodule

// File: rtl/sdbank_multi_switch.sv
// Multi-bank frame buffer switch: writer and reader rotate over NUM_BANKS banks
// so they never share a bank. Optional drop/repeat counters with SDBANK_STATS_EN.
module sdbank_multi_switch
    import sdbank_pkg::*;
#(
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bank_valid,
    input  logic              frame_write_done,
    input  logic              frame_read_done,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              wr_load,
    output logic              rd_load,
    output logic              frame_drop,
    output logic              frame_repeat
`ifdef SDBANK_STATS_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
`endif
);

    generate
        if (NUM_BANKS < 3 || NUM_BANKS > MAX_BANKS ||
            NUM_BANKS > (1 << BANK_W) || CNT_W < 1) begin : g_bad_cfg
            $error("sdbank_multi_switch: illegal parameter set");
        end
    endgenerate

    wr_state_t         wr_state;
    wr_state_t         wr_state_next;
    rd_state_t         rd_state;
    rd_state_t         rd_state_next;
    logic              switch_flag;
    logic              write_evt;
    logic              read_evt;
    logic              drop_evt;
    logic              repeat_evt;
    logic [BANK_W-1:0] latest;
    logic              latest_vld;

    // Lowest bank index that is neither of the two excluded banks.
    function automatic logic [BANK_W-1:0] pick_free(input logic [BANK_W-1:0] a,
                                                    input logic [BANK_W-1:0] b);
        pick_free = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (BANK_W'(i) != a && BANK_W'(i) != b)
                pick_free = BANK_W'(i);
        end
    endfunction

    sdbank_edge_det u_edge_det (
        .clk         (clk),
        .rst_n       (rst_n),
        .bank_valid  (bank_valid),
        .switch_flag (switch_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        write_evt     = 1'b0;
        case (wr_state)
            W_IDLE:      wr_state_next = W_ARM;
            W_ARM:       wr_state_next = W_WAIT_SYNC;
            W_WAIT_SYNC: if (switch_flag) wr_state_next = W_LOAD;
            W_LOAD:      wr_state_next = W_WAIT_DONE;
            W_WAIT_DONE: begin
                if (frame_write_done) begin
                    write_evt     = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            default:     wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        read_evt      = 1'b0;
        case (rd_state)
            R_IDLE:      rd_state_next = R_LOAD;
            R_LOAD:      rd_state_next = R_GAP;
            R_GAP:       rd_state_next = R_WAIT_SYNC;
            R_WAIT_SYNC: if (switch_flag) rd_state_next = R_WAIT_DONE;
            R_WAIT_DONE: begin
                if (frame_read_done) begin
                    read_evt      = 1'b1;
                    rd_state_next = R_IDLE;
                end
            end
            default:     rd_state_next = R_IDLE;
        endcase
    end

    // A simultaneous read completion consumes the new frame, so nothing is lost.
    assign drop_evt   = write_evt & ~read_evt & latest_vld;
    assign repeat_evt = read_evt & ~write_evt & ~latest_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank      <= '0;
            rd_bank      <= BANK_W'(NUM_BANKS - 1);
            latest       <= '0;
            latest_vld   <= 1'b0;
            wr_load      <= 1'b0;
            rd_load      <= 1'b0;
            frame_drop   <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            wr_load      <= (wr_state_next == W_LOAD);
            rd_load      <= (rd_state_next == R_LOAD);
            frame_drop   <= drop_evt;
            frame_repeat <= repeat_evt;
            if (write_evt && read_evt) begin
                rd_bank    <= wr_bank;
                latest     <= wr_bank;
                latest_vld <= 1'b0;
                wr_bank    <= pick_free(wr_bank, rd_bank);
            end else if (write_evt) begin
                latest     <= wr_bank;
                latest_vld <= 1'b1;
                wr_bank    <= pick_free(wr_bank, rd_bank);
            end else if (read_evt && latest_vld) begin
                rd_bank    <= latest;
                latest_vld <= 1'b0;
            end
        end
    end

`ifdef SDBANK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (drop_evt && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            if (repeat_evt && repeat_cnt != '1)
                repeat_cnt <= repeat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdbank_multi_switch.sv
// Bench for sdbank_multi_switch: directed frame sequences plus a random phase,
// checked every cycle against a behavioural model of the bank rotation rules.
module tb_sdbank_multi_switch;

    localparam int NB = 3;
    localparam int BW = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bank_valid = 1'b0;
    logic          frame_write_done = 1'b0;
    logic          frame_read_done = 1'b0;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic          wr_load;
    logic          rd_load;
    logic          frame_drop;
    logic          frame_repeat;
`ifdef SDBANK_STATS_EN
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] repeat_cnt;
`endif

    always #5 clk = ~clk;

    sdbank_multi_switch #(.NUM_BANKS(NB), .BANK_W(BW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bank_valid       (bank_valid),
        .frame_write_done (frame_write_done),
        .frame_read_done  (frame_read_done),
        .wr_bank          (wr_bank),
        .rd_bank          (rd_bank),
        .wr_load          (wr_load),
        .rd_load          (rd_load),
        .frame_drop       (frame_drop),
        .frame_repeat     (frame_repeat)
`ifdef SDBANK_STATS_EN
        ,
        .drop_cnt         (drop_cnt),
        .repeat_cnt       (repeat_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit p1, p2;
    int m_wr, m_rd, m_lat;
    bit m_lv;
    bit e_wrl, e_rdl, e_drop, e_rep;
    int w_cd, w_busy, r_cd;
    bit r_wait;
    int e_dcnt, e_rcnt;

    function automatic int free_bank(input int a, input int b);
        for (int k = 0; k < NB; k++)
            if (k != a && k != b) return k;
        return 0;
    endfunction

    task automatic model_reset();
        p1 = 0; p2 = 0;
        m_wr = 0; m_rd = NB - 1; m_lat = 0; m_lv = 0;
        e_wrl = 0; e_rdl = 0; e_drop = 0; e_rep = 0;
        w_cd = 2; w_busy = 0; r_cd = 3; r_wait = 0;
        e_dcnt = 0; e_rcnt = 0;
    endtask

    task automatic model_step();
        bit sf, wevt, revt;
        int free;
        sf = p2 & ~p1;
        p2 = p1;
        p1 = bank_valid;
        wevt = (w_busy == 2) && frame_write_done;
        revt = r_wait && frame_read_done;
        e_wrl = 0; e_rdl = 0; e_drop = 0; e_rep = 0;
        // writer progress: two dead cycles, then listen for sync, one load cycle, then wait
        if (w_busy == 2) begin
            if (frame_write_done) begin w_busy = 0; w_cd = 2; end
        end else if (w_busy == 1) w_busy = 2;
        else if (w_cd > 0) w_cd--;
        else if (sf) begin w_busy = 1; e_wrl = 1; end
        // reader progress: load pulse, gap, then listen for sync, then wait
        if (r_wait) begin
            if (frame_read_done) begin r_wait = 0; r_cd = 3; end
        end else if (r_cd > 0) begin
            if (r_cd == 3) e_rdl = 1;
            r_cd--;
        end else if (sf) r_wait = 1;
        free = free_bank(m_wr, m_rd);
        if (wevt && revt) begin
            m_rd = m_wr; m_lv = 0; m_wr = free;
        end else if (wevt) begin
            e_drop = m_lv; m_lat = m_wr; m_lv = 1; m_wr = free;
        end else if (revt) begin
            if (m_lv) begin m_rd = m_lat; m_lv = 0; end
            else e_rep = 1;
        end
        if (e_drop && e_dcnt < (1 << CW) - 1) e_dcnt++;
        if (e_rep && e_rcnt < (1 << CW) - 1) e_rcnt++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("wr_bank", 32'(wr_bank), 32'(m_wr));
            check("rd_bank", 32'(rd_bank), 32'(m_rd));
            check("wr_load", 32'(wr_load), 32'(e_wrl));
            check("rd_load", 32'(rd_load), 32'(e_rdl));
            check("frame_drop", 32'(frame_drop), 32'(e_drop));
            check("frame_repeat", 32'(frame_repeat), 32'(e_rep));
            check("banks_distinct", 32'(wr_bank != rd_bank), 32'd1);
`ifdef SDBANK_STATS_EN
            check("drop_cnt", 32'(drop_cnt), 32'(e_dcnt));
            check("repeat_cnt", 32'(repeat_cnt), 32'(e_rcnt));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic sync_frame();
        bank_valid = 1'b1;
        step(1);
        bank_valid = 1'b0;
        step(3);
    endtask

    // Drive done strobes for one edge; returns at the negedge where results are visible.
    task automatic fire(input logic w, input logic r);
        frame_write_done = w;
        frame_read_done  = r;
        @(negedge clk);
    endtask

    task automatic clr();
        #1;
        frame_write_done = 1'b0;
        frame_read_done  = 1'b0;
    endtask

    initial begin
        int rd_sum, wr_sum;
        step(3);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd2);
        check("rst_loads", 32'({wr_load, rd_load, frame_drop, frame_repeat}), 32'd0);
        rst_n = 1'b1;

        rd_sum = 0; wr_sum = 0;
        repeat (4) begin
            @(negedge clk);
            rd_sum += int'(rd_load);
            wr_sum += int'(wr_load);
        end
        #1;
        check("boot_rd_load_once", 32'(rd_sum), 32'd1);
        check("boot_no_wr_load", 32'(wr_sum), 32'd0);

        sync_frame();
        fire(1'b0, 1'b1);
        check("repeat_pulse", 32'(frame_repeat), 32'd1);
        check("repeat_rd_stays", 32'(rd_bank), 32'd2);
        clr();

        fire(1'b1, 1'b0);
        check("wr1_wr_bank", 32'(wr_bank), 32'd1);
        check("wr1_no_drop", 32'(frame_drop), 32'd0);
        check("wr1_model_lv", 32'(m_lv), 32'd1);
        check("wr1_model_latest", 32'(m_lat), 32'd0);
        clr();

        step(5);
        sync_frame();
        fire(1'b1, 1'b0);
        check("wr2_drop", 32'(frame_drop), 32'd1);
        check("wr2_wr_bank", 32'(wr_bank), 32'd0);
        check("wr2_model_latest", 32'(m_lat), 32'd1);
        clr();

        fire(1'b0, 1'b1);
        check("rd_takes_latest", 32'(rd_bank), 32'd1);
        check("rd_no_repeat", 32'(frame_repeat), 32'd0);
        check("rd_wr_bank", 32'(wr_bank), 32'd0);
        clr();

        // reset while both sides are mid-frame
        step(5);
        sync_frame();
        rst_n = 1'b0;
        step(2);
        check("midrst_wr_bank", 32'(wr_bank), 32'd0);
        check("midrst_rd_bank", 32'(rd_bank), 32'd2);
        rst_n = 1'b1;
        rd_sum = 0;
        repeat (2) begin
            @(negedge clk);
            rd_sum += int'(rd_load);
        end
        #1;
        check("midrst_rd_load_2cyc", 32'(rd_sum), 32'd1);
        step(3);
        sync_frame();
        fire(1'b1, 1'b1);
        check("both_rd_bank", 32'(rd_bank), 32'd0);
        check("both_wr_bank", 32'(wr_bank), 32'd1);
        check("both_no_drop", 32'(frame_drop), 32'd0);
        check("both_no_repeat", 32'(frame_repeat), 32'd0);
        clr();

        repeat (5) begin
            step(5);
            sync_frame();
            fire(1'b0, 1'b1);
            check("forced_repeat", 32'(frame_repeat), 32'd1);
            clr();
        end
`ifdef SDBANK_STATS_EN
        step(1);
        check("repeat_cnt_sat", 32'(repeat_cnt), 32'd3);
        check("drop_cnt_zero", 32'(drop_cnt), 32'd0);
`endif

        // random phase; bank_valid held for stretches so syncs actually occur
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 5) == 0) bank_valid = ~bank_valid;
            frame_write_done = ($urandom_range(0, 5) == 0);
            frame_read_done  = ($urandom_range(0, 5) == 0);
            step(1);
        end
        frame_write_done = 1'b0;
        frame_read_done  = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
